nvram_ctrl: RTL and testbench

Parametrised successor to the fixed 8 kB byte NVRAM.
- Owns a true dual-port NVRAM with a 68000-style CPU slave port (UDS/LDS lanes, ACK generation) and a byte-wide HPS backup/restore port.
- Adds configurable depth and lane width, a one-ACK-per-access state machine, per-block dirty tracking, and a debounced save request so HPS only backs up blocks that changed.
- Sits in cditop on the attex NVRAM chip-select.

---
 rtl/nvram_ctrl.sv | 159 +++++++++++++++
 tb/tb_nvram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_ctrl.sv
// nvram_ctrl - dual-port NVRAM with a 68000-style CPU slave port and a
// byte-wide HPS backup/restore port, plus dirty-block tracking and a
// debounced save request.
//
// Ports:
//   clk30, reset            clock, asynchronous active-high reset
//   cpu_addr/din/dout       CPU word address, write data, read data
//   cpu_uds/lds             upper/lower data strobes
//   cpu_write_strobe        1 = write cycle
//   cs                      decoded, AS-qualified chip select
//   cpu_bus_ack             DTACK, exactly one per chip-select assertion
//   allow_cpu_access        0 stalls the CPU port (HPS restore running)
//   cpu_changed             one-cycle pulse after each committed CPU write
//   hps_addr/wdata/we       HPS byte address, restore data, restore write
//   hps_rdata               backup data, one cycle after hps_addr
//   dirty_idx/dirty         block query, dirty bit of that block
//   dirty_clear             clear dirty bit of dirty_idx
//   any_dirty               OR of all dirty bits
//   save_request            backup recommended (level)
//   fsm_state               debug view of the access FSM
//
// Handshake: an access is cs && (uds || lds). A write is acked in the cycle it
// is first seen in IDLE and commits on that edge; a read is acked one cycle
// later with registered RAM data. After the ack the FSM parks in HOLD until cs
// drops, so one chip-select assertion yields one ack and at most one write.
module nvram_ctrl #(
  parameter int ADDR_WIDTH    = 13,
  parameter int BYTE_LANES    = 1,
  parameter int BLOCK_SHIFT   = 9,
  parameter int SETTLE_CYCLES = 3000000
) (
  input  logic                                          clk30,
  input  logic                                          reset,
  input  logic [ADDR_WIDTH-1:0]                         cpu_addr,
  input  logic [15:0]                                   cpu_din,
  output logic [15:0]                                   cpu_dout,
  input  logic                                          cpu_uds,
  input  logic                                          cpu_lds,
  input  logic                                          cpu_write_strobe,
  input  logic                                          cs,
  output logic                                          cpu_bus_ack,
  input  logic                                          allow_cpu_access,
  output logic                                          cpu_changed,
  input  logic [ADDR_WIDTH+BYTE_LANES-2:0]              hps_addr,
  input  logic [7:0]                                    hps_wdata,
  input  logic                                          hps_we,
  output logic [7:0]                                    hps_rdata,
  input  logic [ADDR_WIDTH+BYTE_LANES-2-BLOCK_SHIFT:0]  dirty_idx,
  output logic                                          dirty,
  input  logic                                          dirty_clear,
  output logic                                          any_dirty,
  output logic                                          save_request,
  output logic [1:0]                                    fsm_state
);

  localparam int HA = ADDR_WIDTH + BYTE_LANES - 1;  // HPS byte address bits
  localparam int DW = HA - BLOCK_SHIFT;             // dirty index bits
  localparam int NB = 1 << DW;                      // number of dirty blocks
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, HOLD = 2'd2} state_t;
  state_t state;

  logic access, cpu_we, commit;
  logic we_e, we_o, hps_we_e, hps_we_o;
  logic [ADDR_WIDTH-1:0] hps_word;
  logic hps_lane;
  logic [HA-1:0] cpu_byte_addr;
  logic [DW-1:0] set_idx;
  logic [NB-1:0] dirty_bits;
  logic [CW-1:0] settle_cnt;
  logic wrote;

  assign access = cs && (cpu_uds || cpu_lds);
  assign cpu_we = (state == IDLE) && access && allow_cpu_access && cpu_write_strobe;
  assign cpu_bus_ack = !reset &&
                       (cpu_we || (state == RD_WAIT));
  assign fsm_state = state;

  // Even bank holds the upper lane (the only bank when BYTE_LANES = 1).
  logic [7:0] mem_e [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] q_e;

  assign we_e     = cpu_we && cpu_uds;
  assign hps_we_e = hps_we && !hps_lane;
  assign commit   = we_e || we_o;

  // The HPS write is placed second so it wins a same-byte collision.
  always_ff @(posedge clk30) begin
    if (we_e)     mem_e[cpu_addr] <= cpu_din[15:8];
    if (hps_we_e) mem_e[hps_word] <= hps_wdata;
    q_e <= mem_e[cpu_addr];
  end

  generate
    if (BYTE_LANES == 1) begin : g_one
      assign hps_word = hps_addr;
      assign hps_lane = 1'b0;
      assign we_o     = 1'b0;
      assign hps_we_o = 1'b0;
      assign cpu_dout = {q_e, q_e};
      always_ff @(posedge clk30) hps_rdata <= mem_e[hps_word];
    end else begin : g_two
      logic [7:0] mem_o [0:(1<<ADDR_WIDTH)-1];
      logic [7:0] q_o;
      assign hps_word = hps_addr[HA-1:1];
      assign hps_lane = hps_addr[0];
      assign we_o     = cpu_we && cpu_lds;
      assign hps_we_o = hps_we && hps_lane;
      assign cpu_dout = {q_e, q_o};
      always_ff @(posedge clk30) begin
        if (we_o)     mem_o[cpu_addr] <= cpu_din[7:0];
        if (hps_we_o) mem_o[hps_word] <= hps_wdata;
        q_o <= mem_o[cpu_addr];
        hps_rdata <= hps_lane ? mem_o[hps_word] : mem_e[hps_word];
      end
    end
  endgenerate

  // Both lanes of a word share a block, so the even byte address suffices.
  assign cpu_byte_addr = HA'(cpu_addr) << (BYTE_LANES - 1);
  assign set_idx       = cpu_byte_addr[HA-1:BLOCK_SHIFT];

  assign dirty        = dirty_bits[dirty_idx];
  assign any_dirty    = |dirty_bits;
  assign save_request = any_dirty && (settle_cnt == '0) && wrote;

  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cpu_changed <= 1'b0;
      dirty_bits  <= '0;
      settle_cnt  <= '0;
      wrote       <= 1'b0;
    end else begin
      cpu_changed <= commit;

      case (state)
        IDLE:    if (access && allow_cpu_access)
                   state <= cpu_write_strobe ? HOLD : RD_WAIT;
        RD_WAIT: state <= cs ? HOLD : IDLE;
        HOLD:    if (!cs) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Clear first so a coincident set of the same block wins.
      if (dirty_clear) dirty_bits[dirty_idx] <= 1'b0;
      if (commit)      dirty_bits[set_idx]   <= 1'b1;

      if (commit) begin
        settle_cnt <= CW'(SETTLE_CYCLES);
        wrote      <= 1'b1;
      end else if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nvram_ctrl.sv
// Directed bench for nvram_ctrl: dut_a is the byte-wide MONO1 build with a
// short settle time, dut_b is the 16-bit two-lane build.
module tb_nvram_ctrl;

  logic clk30 = 1'b0;
  logic reset;
  always #5 clk30 = ~clk30;

  int n_checks = 0;
  int n_fail   = 0;

  // dut_a: BYTE_LANES = 1
  logic [12:0] a_addr;
  logic [15:0] a_din, a_dout;
  logic a_uds, a_lds, a_wr, a_cs, a_ack, a_allow, a_changed;
  logic [12:0] a_hps_addr;
  logic [7:0] a_hps_wdata, a_hps_rdata;
  logic a_hps_we;
  logic [3:0] a_didx;
  logic a_dirty, a_dclr, a_any, a_save;
  logic [1:0] a_state;

  // dut_b: BYTE_LANES = 2
  logic [12:0] b_addr;
  logic [15:0] b_din, b_dout;
  logic b_uds, b_lds, b_wr, b_cs, b_ack, b_allow, b_changed;
  logic [13:0] b_hps_addr;
  logic [7:0] b_hps_wdata, b_hps_rdata;
  logic b_hps_we;
  logic [4:0] b_didx;
  logic b_dirty, b_dclr, b_any, b_save;
  logic [1:0] b_state;

  nvram_ctrl #(.ADDR_WIDTH(13), .BYTE_LANES(1), .BLOCK_SHIFT(9), .SETTLE_CYCLES(16)) dut_a (
    .clk30(clk30), .reset(reset), .cpu_addr(a_addr), .cpu_din(a_din), .cpu_dout(a_dout),
    .cpu_uds(a_uds), .cpu_lds(a_lds), .cpu_write_strobe(a_wr), .cs(a_cs),
    .cpu_bus_ack(a_ack), .allow_cpu_access(a_allow), .cpu_changed(a_changed),
    .hps_addr(a_hps_addr), .hps_wdata(a_hps_wdata), .hps_we(a_hps_we), .hps_rdata(a_hps_rdata),
    .dirty_idx(a_didx), .dirty(a_dirty), .dirty_clear(a_dclr), .any_dirty(a_any),
    .save_request(a_save), .fsm_state(a_state)
  );

  nvram_ctrl #(.ADDR_WIDTH(13), .BYTE_LANES(2), .BLOCK_SHIFT(9), .SETTLE_CYCLES(16)) dut_b (
    .clk30(clk30), .reset(reset), .cpu_addr(b_addr), .cpu_din(b_din), .cpu_dout(b_dout),
    .cpu_uds(b_uds), .cpu_lds(b_lds), .cpu_write_strobe(b_wr), .cs(b_cs),
    .cpu_bus_ack(b_ack), .allow_cpu_access(b_allow), .cpu_changed(b_changed),
    .hps_addr(b_hps_addr), .hps_wdata(b_hps_wdata), .hps_we(b_hps_we), .hps_rdata(b_hps_rdata),
    .dirty_idx(b_didx), .dirty(b_dirty), .dirty_clear(b_dclr), .any_dirty(b_any),
    .save_request(b_save), .fsm_state(b_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk30);
    #1;
  endtask

  task automatic a_idle_bus();
    a_cs = 1'b0; a_uds = 1'b0; a_lds = 1'b0; a_wr = 1'b0;
  endtask

  task automatic a_hps_write(input logic [12:0] addr, input logic [7:0] data);
    a_hps_addr = addr; a_hps_wdata = data; a_hps_we = 1'b1;
    step();
    a_hps_we = 1'b0;
  endtask

  task automatic a_hps_read(input logic [12:0] addr, output logic [7:0] data);
    a_hps_addr = addr;
    step();
    data = a_hps_rdata;
  endtask

  task automatic b_hps_write(input logic [13:0] addr, input logic [7:0] data);
    b_hps_addr = addr; b_hps_wdata = data; b_hps_we = 1'b1;
    step();
    b_hps_we = 1'b0;
  endtask

  task automatic b_hps_read(input logic [13:0] addr, output logic [7:0] data);
    b_hps_addr = addr;
    step();
    data = b_hps_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", a_ack); end
    n_checks++; if (a_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b want 0", a_changed); end
    n_checks++; if (a_save !== 1'b0) begin n_fail++; $display("FAIL reset_save got %b want 0", a_save); end
    n_checks++; if (a_any !== 1'b0) begin n_fail++; $display("FAIL reset_any_dirty got %b want 0", a_any); end
    n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", a_state); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    int acks = 0, chg = 0, chg_at = -1;
    logic ack0;
    logic [7:0] d;
    a_addr = 13'h0010; a_din = 16'hA5C3; a_wr = 1'b1; a_uds = 1'b1; a_lds = 1'b0; a_cs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk30);
      if (i == 0) ack0 = a_ack;
      if (a_ack) acks++;
      if (a_changed) begin chg++; chg_at = i; end
      step();
    end
    a_idle_bus();
    step();
    n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL wr_ack_first got %b want 1", ack0); end
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL wr_ack_count got %0d want 1", acks); end
    n_checks++; if (chg != 1 || chg_at != 1) begin n_fail++; $display("FAIL wr_changed got count %0d at %0d want 1 at 1", chg, chg_at); end
    a_hps_read(13'h0010, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wr_hps_readback got %h want a5", d); end
    a_didx = 4'd0;
    #1;
    n_checks++; if (a_dirty !== 1'b1) begin n_fail++; $display("FAIL wr_dirty0 got %b want 1", a_dirty); end
  endtask

  task automatic test_read();
    int acks = 0, ack_at = -1;
    logic [15:0] dout_at_ack = 16'h0;
    a_addr = 13'h0010; a_wr = 1'b0; a_uds = 1'b1; a_lds = 1'b1; a_cs = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk30);
      if (a_ack) begin acks++; ack_at = i; dout_at_ack = a_dout; end
      step();
    end
    a_idle_bus();
    step();
    n_checks++; if (acks != 1 || ack_at != 1) begin n_fail++; $display("FAIL rd_ack got count %0d at %0d want 1 at 1", acks, ack_at); end
    n_checks++; if (dout_at_ack !== 16'hA5A5) begin n_fail++; $display("FAIL rd_dout got %h want a5a5", dout_at_ack); end
  endtask

  task automatic test_lds_only();
    logic [7:0] d;
    logic ack_seen = 1'b0, chg_seen = 1'b0;
    a_hps_write(13'h0030, 8'h22);
    a_addr = 13'h0030; a_din = 16'h0077; a_wr = 1'b1; a_uds = 1'b0; a_lds = 1'b1; a_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk30);
      if (a_ack) ack_seen = 1'b1;
      if (a_changed) chg_seen = 1'b1;
      step();
    end
    a_idle_bus();
    @(negedge clk30);
    if (a_changed) chg_seen = 1'b1;
    step();
    n_checks++; if (ack_seen !== 1'b1) begin n_fail++; $display("FAIL lds_ack got %b want 1", ack_seen); end
    n_checks++; if (chg_seen !== 1'b0) begin n_fail++; $display("FAIL lds_changed got %b want 0", chg_seen); end
    a_hps_read(13'h0030, d);
    n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL lds_mem got %h want 22", d); end
  endtask

  task automatic test_allow();
    int acks = 0, chg = 0;
    logic [7:0] d;
    a_hps_write(13'h0020, 8'h11);
    a_allow = 1'b0;
    a_addr = 13'h0020; a_din = 16'h5A00; a_wr = 1'b1; a_uds = 1'b1; a_lds = 1'b0; a_cs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk30);
      if (a_ack) acks++;
      if (a_changed) chg++;
      step();
    end
    n_checks++; if (acks != 0 || chg != 0) begin n_fail++; $display("FAIL stall_ack got acks %0d changed %0d want 0 0", acks, chg); end
    a_hps_read(13'h0020, d);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL stall_mem got %h want 11", d); end
    a_allow = 1'b1;
    @(negedge clk30);
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL allow_ack got %b want 1", a_ack); end
    step();
    a_idle_bus();
    @(negedge clk30);
    n_checks++; if (a_changed !== 1'b1) begin n_fail++; $display("FAIL allow_changed got %b want 1", a_changed); end
    step();
    a_hps_read(13'h0020, d);
    n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL allow_mem got %h want 5a", d); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    logic ack_c;
    a_addr = 13'h0040; a_din = 16'h9900; a_wr = 1'b1; a_uds = 1'b1; a_lds = 1'b0; a_cs = 1'b1;
    a_hps_addr = 13'h0040; a_hps_wdata = 8'h66; a_hps_we = 1'b1;
    @(negedge clk30);
    ack_c = a_ack;
    step();
    a_hps_we = 1'b0;
    a_idle_bus();
    @(negedge clk30);
    n_checks++; if (ack_c !== 1'b1) begin n_fail++; $display("FAIL coll_ack got %b want 1", ack_c); end
    n_checks++; if (a_changed !== 1'b1) begin n_fail++; $display("FAIL coll_changed got %b want 1", a_changed); end
    step();
    a_hps_read(13'h0040, d);
    n_checks++; if (d !== 8'h66) begin n_fail++; $display("FAIL coll_mem got %h want 66", d); end
  endtask

  task automatic test_settle();
    int first_hi = -1;
    a_didx = 4'd0; a_dclr = 1'b1;
    step();
    a_dclr = 1'b0;
    #1;
    n_checks++; if (a_any !== 1'b0 || a_save !== 1'b0) begin n_fail++; $display("FAIL settle_clear got any %b save %b want 0 0", a_any, a_save); end
    // Write in cycle 0; it commits at the end of cycle 0 and loads 16, so
    // the counter reaches zero 16 edges later, in cycle 17.
    a_addr = 13'h0010; a_din = 16'hA5C3; a_wr = 1'b1; a_uds = 1'b1; a_lds = 1'b0; a_cs = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk30);
      if (a_save && first_hi < 0) first_hi = k;
      step();
      if (k == 0) a_idle_bus();
    end
    n_checks++; if (first_hi != 17) begin n_fail++; $display("FAIL settle_rise got cycle %0d want 17", first_hi); end
    a_didx = 4'd0; a_dclr = 1'b1;
    step();
    a_dclr = 1'b0;
    @(negedge clk30);
    n_checks++; if (a_save !== 1'b0 || a_dirty !== 1'b0) begin n_fail++; $display("FAIL settle_clear_fall got save %b dirty %b want 0 0", a_save, a_dirty); end
    step();
    a_wr = 1'b1; a_uds = 1'b1; a_cs = 1'b1; a_dclr = 1'b1;
    step();
    a_idle_bus(); a_dclr = 1'b0;
    @(negedge clk30);
    n_checks++; if (a_dirty !== 1'b1) begin n_fail++; $display("FAIL set_wins got dirty %b want 1", a_dirty); end
    n_checks++; if (a_save !== 1'b0) begin n_fail++; $display("FAIL save_after_write got %b want 0", a_save); end
    step();
  endtask

  task automatic test_two_lane();
    logic [7:0] d;
    logic ack_seen = 1'b0;
    logic [15:0] rd = 16'h0;
    b_hps_write(14'h0800, 8'h11);
    b_hps_write(14'h0801, 8'h22);
    b_addr = 13'h0400; b_din = 16'h003C; b_wr = 1'b1; b_uds = 1'b0; b_lds = 1'b1; b_cs = 1'b1;
    @(negedge clk30);
    ack_seen = b_ack;
    step();
    b_cs = 1'b0; b_lds = 1'b0; b_wr = 1'b0;
    step();
    n_checks++; if (ack_seen !== 1'b1) begin n_fail++; $display("FAIL lane2_ack got %b want 1", ack_seen); end
    b_hps_read(14'h0801, d);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL lane2_odd got %h want 3c", d); end
    b_hps_read(14'h0800, d);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL lane2_even got %h want 11", d); end
    b_didx = 5'd4;
    #1;
    n_checks++; if (b_dirty !== 1'b1) begin n_fail++; $display("FAIL lane2_dirty4 got %b want 1", b_dirty); end
    b_didx = 5'd0;
    #1;
    n_checks++; if (b_dirty !== 1'b0) begin n_fail++; $display("FAIL lane2_dirty0 got %b want 0", b_dirty); end
    b_addr = 13'h0400; b_wr = 1'b0; b_uds = 1'b1; b_lds = 1'b1; b_cs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk30);
      if (b_ack) rd = b_dout;
      step();
    end
    b_cs = 1'b0; b_uds = 1'b0; b_lds = 1'b0;
    step();
    n_checks++; if (rd !== 16'h113C) begin n_fail++; $display("FAIL lane2_read got %h want 113c", rd); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    a_addr = 13'h0010; a_wr = 1'b0; a_uds = 1'b1; a_lds = 1'b1; a_cs = 1'b1;
    step();
    n_checks++; if (a_ack !== 1'b1 || a_state !== 2'd1) begin n_fail++; $display("FAIL rst_pre got ack %b state %0d want 1 1", a_ack, a_state); end
    reset = 1'b1;
    #1;
    a_didx = 4'd0;
    #1;
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", a_ack); end
    n_checks++; if (a_dirty !== 1'b0 || a_any !== 1'b0) begin n_fail++; $display("FAIL rst_dirty got %b any %b want 0 0", a_dirty, a_any); end
    n_checks++; if (a_state !== 2'd0 || a_save !== 1'b0) begin n_fail++; $display("FAIL rst_state got %0d save %b want 0 0", a_state, a_save); end
    a_idle_bus();
    step();
    reset = 1'b0;
    step();
    a_hps_read(13'h0010, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rst_mem got %h want a5", d); end
  endtask

  initial begin
    reset = 1'b1;
    a_idle_bus(); a_addr = '0; a_din = '0; a_allow = 1'b1;
    a_hps_addr = '0; a_hps_wdata = '0; a_hps_we = 1'b0; a_didx = '0; a_dclr = 1'b0;
    b_cs = 1'b0; b_uds = 1'b0; b_lds = 1'b0; b_wr = 1'b0; b_addr = '0; b_din = '0; b_allow = 1'b1;
    b_hps_addr = '0; b_hps_wdata = '0; b_hps_we = 1'b0; b_didx = '0; b_dclr = 1'b0;
    #1;
    test_reset();
    test_write();
    test_read();
    test_lds_only();
    test_allow();
    test_collision();
    test_settle();
    test_two_lane();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
